// File: rtl/dcache_refill_controller.sv
// dcache_refill_controller: direct-mapped, write-through, no-write-allocate data cache
// with a single outstanding req/ack memory transaction and load hit/miss counters.
`default_nettype none

module dcache_refill_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 4
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iReq,
  input  logic                  iWriteEn,
  input  logic [DATA_WIDTH-1:0] iAddress,
  input  logic [DATA_WIDTH-1:0] iWriteData,
  input  logic [3:0]            iByteEn,
  input  logic                  iFlush,
  output logic                  oStall,
  output logic [DATA_WIDTH-1:0] oReadData,
  output logic                  oReadValid,
  output logic                  oMemReq,
  output logic                  oMemWe,
  output logic [DATA_WIDTH-1:0] oMemAddr,
  output logic [DATA_WIDTH-1:0] oMemWData,
  output logic [3:0]            oMemByteEn,
  input  logic                  iMemAck,
  input  logic [DATA_WIDTH-1:0] iMemRData,
  output logic [31:0]           oHitCount,
  output logic [31:0]           oMissCount
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS - 2;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] READ_WAIT  = 2'd1;
  localparam logic [1:0] WRITE_WAIT = 2'd2;
  localparam logic [1:0] DONE       = 2'd3;

  logic [1:0]            state;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tags  [LINES];
  logic [DATA_WIDTH-1:0] lines [LINES];
  logic [DATA_WIDTH-1:0] ret_data;

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  hit;
  logic [INDEX_BITS-1:0] cap_index;
  logic [TAG_BITS-1:0]   cap_tag;
  logic                  cap_hit;
  logic [DATA_WIDTH-1:0] merged;

  logic idle_flush;
  logic idle_load_hit;
  logic idle_load_miss;
  logic idle_store;
  logic read_done;
  logic write_done;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{iAddress[1:0], oMemAddr[1:0]};

  assign req_index = iAddress[INDEX_BITS+1:2];
  assign req_tag   = iAddress[DATA_WIDTH-1:INDEX_BITS+2];
  assign hit       = valid[req_index] && (tags[req_index] == req_tag);

  // The captured memory address doubles as the transaction's line index and tag.
  assign cap_index = oMemAddr[INDEX_BITS+1:2];
  assign cap_tag   = oMemAddr[DATA_WIDTH-1:INDEX_BITS+2];
  assign cap_hit   = valid[cap_index] && (tags[cap_index] == cap_tag);

  assign idle_flush     = (state == IDLE) && iFlush;
  assign idle_load_hit  = (state == IDLE) && !iFlush && iReq && !iWriteEn && hit;
  assign idle_load_miss = (state == IDLE) && !iFlush && iReq && !iWriteEn && !hit;
  assign idle_store     = (state == IDLE) && !iFlush && iReq && iWriteEn;
  assign read_done      = (state == READ_WAIT) && iMemAck;
  assign write_done     = (state == WRITE_WAIT) && iMemAck;

  always_comb begin
    merged = lines[cap_index];
    for (int b = 0; b < 4; b++) begin
      if (oMemByteEn[b]) begin
        merged[8*b +: 8] = oMemWData[8*b +: 8];
      end
    end
  end

  always_comb begin
    oStall     = 1'b0;
    oReadData  = '0;
    oReadValid = 1'b0;
    case (state)
      IDLE: begin
        if (iFlush) begin
          oStall = iReq;
        end else if (iReq) begin
          oStall = iWriteEn || !hit;
          if (idle_load_hit) begin
            oReadData  = lines[req_index];
            oReadValid = 1'b1;
          end
        end
      end
      READ_WAIT, WRITE_WAIT: oStall = 1'b1;
      DONE: begin
        if (!oMemWe) begin
          oReadData  = ret_data;
          oReadValid = 1'b1;
        end
      end
      default: oStall = 1'b0;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state      <= IDLE;
      valid      <= '0;
      ret_data   <= '0;
      oMemReq    <= 1'b0;
      oMemWe     <= 1'b0;
      oMemAddr   <= '0;
      oMemWData  <= '0;
      oMemByteEn <= '0;
      oHitCount  <= '0;
      oMissCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_flush) begin
            valid <= '0;
          end else if (idle_load_hit) begin
            oHitCount <= oHitCount + 32'd1;
          end else if (idle_load_miss) begin
            oMissCount <= oMissCount + 32'd1;
            oMemReq    <= 1'b1;
            oMemWe     <= 1'b0;
            oMemAddr   <= {iAddress[DATA_WIDTH-1:2], 2'b00};
            state      <= READ_WAIT;
          end else if (idle_store) begin
            oMemReq    <= 1'b1;
            oMemWe     <= 1'b1;
            oMemAddr   <= {iAddress[DATA_WIDTH-1:2], 2'b00};
            oMemWData  <= iWriteData;
            oMemByteEn <= iByteEn;
            state      <= WRITE_WAIT;
          end
        end
        READ_WAIT: begin
          if (read_done) begin
            valid[cap_index] <= 1'b1;
            ret_data         <= iMemRData;
            oMemReq          <= 1'b0;
            state            <= DONE;
          end
        end
        WRITE_WAIT: begin
          if (write_done) begin
            oMemReq <= 1'b0;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      if (read_done) begin
        tags[cap_index]  <= cap_tag;
        lines[cap_index] <= iMemRData;
      end else if (write_done && cap_hit) begin
        lines[cap_index] <= merged;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_refill_controller.sv
// Directed self-checking bench for dcache_refill_controller with a scripted memory responder.
`default_nettype none

module tb_dcache_refill_controller;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iReq;
  logic        iWriteEn;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic [3:0]  iByteEn;
  logic        iFlush;
  logic        oStall;
  logic [31:0] oReadData;
  logic        oReadValid;
  logic        oMemReq;
  logic        oMemWe;
  logic [31:0] oMemAddr;
  logic [31:0] oMemWData;
  logic [3:0]  oMemByteEn;
  logic        iMemAck;
  logic [31:0] iMemRData;
  logic [31:0] oHitCount;
  logic [31:0] oMissCount;

  int total = 0;
  int bad   = 0;

  int          n_stall;
  logic        r_valid;
  logic [31:0] r_data;
  logic        mem_seen;
  logic [31:0] mem_addr_seen;
  logic        mem_we_seen;
  logic [3:0]  mem_be_seen;
  logic [31:0] mem_wd_seen;
  logic        addr_stable;

  dcache_refill_controller #(.DATA_WIDTH(32), .INDEX_BITS(4)) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iWriteEn(iWriteEn), .iAddress(iAddress),
    .iWriteData(iWriteData), .iByteEn(iByteEn), .iFlush(iFlush), .oStall(oStall),
    .oReadData(oReadData), .oReadValid(oReadValid), .oMemReq(oMemReq), .oMemWe(oMemWe),
    .oMemAddr(oMemAddr), .oMemWData(oMemWData), .oMemByteEn(oMemByteEn), .iMemAck(iMemAck),
    .iMemRData(iMemRData), .oHitCount(oHitCount), .oMissCount(oMissCount)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One request held until oStall drops; memory acks in its delay-th request cycle.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] rd, input int delay,
                        input logic scramble);
    int  wait_cnt;
    logic done;
    @(posedge iClk); #1;
    iReq = 1'b1; iWriteEn = we; iAddress = addr; iWriteData = wd; iByteEn = be;
    n_stall = 0; wait_cnt = 0; mem_seen = 1'b0; addr_stable = 1'b1; done = 1'b0;
    r_valid = 1'b0; r_data = '0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (oMemReq) begin
        if (!mem_seen) begin
          mem_addr_seen = oMemAddr; mem_we_seen = oMemWe;
          mem_be_seen = oMemByteEn; mem_wd_seen = oMemWData;
        end else if (oMemAddr !== mem_addr_seen) begin
          addr_stable = 1'b0;
        end
        mem_seen = 1'b1;
        wait_cnt++;
        iMemAck = (wait_cnt >= delay);
        iMemRData = rd;
        if (scramble) begin
          iAddress = addr ^ (32'h0000_0F0C + 32'(wait_cnt));
          iWriteData = 32'h5555_0000 + 32'(wait_cnt);
        end
      end
      if (!oStall) begin
        r_valid = oReadValid; r_data = oReadData; done = 1'b1;
        break;
      end
      n_stall++;
      @(posedge iClk); #1;
      iMemAck = 1'b0;
    end
    if (!done) check("access_timeout", 32'd0, 32'd1);
    @(posedge iClk); #1;
    iReq = 1'b0; iMemAck = 1'b0; iAddress = addr;
  endtask

  initial begin
    iRst = 1'b1; iReq = 1'b0; iWriteEn = 1'b0; iAddress = '0; iWriteData = '0;
    iByteEn = '0; iFlush = 1'b0; iMemAck = 1'b0; iMemRData = '0;
    repeat (2) @(posedge iClk);
    #1;
    check("rst_stall", 32'(oStall), 32'd0);
    check("rst_rvalid", 32'(oReadValid), 32'd0);
    check("rst_memreq", 32'(oMemReq), 32'd0);
    check("rst_memwe", 32'(oMemWe), 32'd0);
    check("rst_rdata", oReadData, 32'd0);
    check("rst_memaddr", oMemAddr, 32'd0);
    check("rst_memwdata", oMemWData, 32'd0);
    check("rst_membe", 32'(oMemByteEn), 32'd0);
    check("rst_hits", oHitCount, 32'd0);
    check("rst_misses", oMissCount, 32'd0);
    iRst = 1'b0;

    // Cold load miss, ack in first request cycle
    access(1'b0, 32'h40, '0, 4'h0, 32'hDEAD_BEEF, 1, 1'b0);
    check("miss_memseen", 32'(mem_seen), 32'd1);
    check("miss_memaddr", mem_addr_seen, 32'h40);
    check("miss_memwe", 32'(mem_we_seen), 32'd0);
    check("miss_stall", 32'(n_stall), 32'd2);
    check("miss_rvalid", 32'(r_valid), 32'd1);
    check("miss_rdata", r_data, 32'hDEAD_BEEF);
    check("miss_cnt1", oMissCount, 32'd1);

    // Same word, different offset: zero-latency hit
    access(1'b0, 32'h43, '0, 4'h0, 32'h0, 1, 1'b0);
    check("hit_stall", 32'(n_stall), 32'd0);
    check("hit_nomem", 32'(mem_seen), 32'd0);
    check("hit_rdata", r_data, 32'hDEAD_BEEF);
    check("hit_rvalid", 32'(r_valid), 32'd1);
    check("hit_cnt1", oHitCount, 32'd1);

    // Single-byte store hit merges into the line
    access(1'b1, 32'h41, 32'h0000_AA00, 4'b0010, 32'h0, 1, 1'b0);
    check("st_memwe", 32'(mem_we_seen), 32'd1);
    check("st_membe", 32'(mem_be_seen), 32'b0010);
    check("st_memaddr", mem_addr_seen, 32'h40);
    check("st_memwd", mem_wd_seen, 32'h0000_AA00);
    check("st_stall", 32'(n_stall), 32'd2);
    check("st_rvalid", 32'(r_valid), 32'd0);
    check("st_cnts", {oHitCount[15:0], oMissCount[15:0]}, {16'd1, 16'd1});
    access(1'b0, 32'h40, '0, 4'h0, 32'h0, 1, 1'b0);
    check("merge_nomem", 32'(mem_seen), 32'd0);
    check("merge_rdata", r_data, 32'hDEAD_AAEF);

    // Store miss does not allocate
    access(1'b1, 32'h84, 32'h1111_2222, 4'hF, 32'h0, 1, 1'b0);
    check("stmiss_mem", 32'(mem_seen), 32'd1);
    access(1'b0, 32'h84, '0, 4'h0, 32'hCAFE_F00D, 1, 1'b0);
    check("noalloc_memseen", 32'(mem_seen), 32'd1);
    check("noalloc_rdata", r_data, 32'hCAFE_F00D);

    // Store with no byte enables still goes to memory, line unchanged
    access(1'b1, 32'h40, 32'hFFFF_FFFF, 4'h0, 32'h0, 1, 1'b0);
    check("be0_memseen", 32'(mem_seen), 32'd1);
    check("be0_membe", 32'(mem_be_seen), 32'd0);
    access(1'b0, 32'h40, '0, 4'h0, 32'h0, 1, 1'b0);
    check("be0_hit", 32'(mem_seen), 32'd0);
    check("be0_rdata", r_data, 32'hDEAD_AAEF);
    check("cnts_a", {oHitCount[15:0], oMissCount[15:0]}, {16'd3, 16'd2});

    // Conflict eviction
    access(1'b0, 32'h440, '0, 4'h0, 32'h1234_5678, 1, 1'b0);
    check("conf_miss", 32'(mem_seen), 32'd1);
    check("conf_rdata", r_data, 32'h1234_5678);
    access(1'b0, 32'h40, '0, 4'h0, 32'hDEAD_AAEF, 1, 1'b0);
    check("conf_evicted", 32'(mem_seen), 32'd1);
    check("conf_memaddr", mem_addr_seen, 32'h40);
    check("cnts_b", {oHitCount[15:0], oMissCount[15:0]}, {16'd3, 16'd4});

    // Ack delayed to the 5th request cycle with address churn
    access(1'b0, 32'h0C, '0, 4'h0, 32'h0BAD_CAFE, 5, 1'b1);
    check("dly_stall", 32'(n_stall), 32'd6);
    check("dly_addr", mem_addr_seen, 32'h0C);
    check("dly_stable", 32'(addr_stable), 32'd1);
    check("dly_rdata", r_data, 32'h0BAD_CAFE);
    access(1'b0, 32'h0C, '0, 4'h0, 32'h0, 1, 1'b0);
    check("dly_rehit", 32'(mem_seen), 32'd0);
    check("cnts_c", {oHitCount[15:0], oMissCount[15:0]}, {16'd4, 16'd5});

    // Flush wins over a same-cycle load
    @(posedge iClk); #1;
    iFlush = 1'b1; iReq = 1'b1; iWriteEn = 1'b0; iAddress = 32'h40;
    #1;
    check("fl_stall", 32'(oStall), 32'd1);
    check("fl_rvalid", 32'(oReadValid), 32'd0);
    @(posedge iClk); #1;
    iFlush = 1'b0; iReq = 1'b0;
    check("fl_nomem", 32'(oMemReq), 32'd0);
    check("fl_cnts", {oHitCount[15:0], oMissCount[15:0]}, {16'd4, 16'd5});
    access(1'b0, 32'h40, '0, 4'h0, 32'hDEAD_AAEF, 1, 1'b0);
    check("fl_miss", 32'(mem_seen), 32'd1);
    check("fl_misscnt", oMissCount, 32'd6);

    // Reset in the middle of a refill
    @(posedge iClk); #1;
    iReq = 1'b1; iWriteEn = 1'b0; iAddress = 32'h80;
    @(posedge iClk); #1;
    check("mr_memreq", 32'(oMemReq), 32'd1);
    iRst = 1'b1; iReq = 1'b0;
    @(posedge iClk); #2;
    check("mr_memreq_off", 32'(oMemReq), 32'd0);
    check("mr_cnts", {oHitCount[15:0], oMissCount[15:0]}, 32'd0);
    iRst = 1'b0;
    access(1'b0, 32'h40, '0, 4'h0, 32'h7777_8888, 1, 1'b0);
    check("mr_miss", 32'(mem_seen), 32'd1);
    check("mr_rdata", r_data, 32'h7777_8888);
    check("mr_misscnt", oMissCount, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_refill_controller.md
# dcache_refill_controller

Direct-mapped, write-through, no-write-allocate data cache with miss/refill sequencing. Sits between the memory stage (which supplies an address, store data and byte enables, and performs load byte/half extraction on the returned word) and the backing data memory. It stalls the pipeline on load misses and on all stores, runs a req/ack transaction to memory, refills or updates the line, and exposes hit/miss counters.

## Interface
- DATA_WIDTH, 32, address/data width.
- INDEX_BITS, 4, line index width (16 lines); tag = DATA_WIDTH-INDEX_BITS-2 bits (26 at defaults), offset = address[1:0].
- iClk  in  1  clock; all state updates on posedge.
- iRst  in  1  synchronous, active-high reset.
- iReq  in  1  memory-stage access request.
- iWriteEn  in  1  1 = store, 0 = load (qualified by iReq).
- iAddress  in  DATA_WIDTH  byte address; [1:0] ignored here.
- iWriteData  in  DATA_WIDTH  store word, already lane-positioned.
- iByteEn  in  4  store byte lanes.
- iFlush  in  1  invalidate all lines.
- oStall  out  1  hold memory stage and upstream.
- oReadData  out  DATA_WIDTH  full aligned load word.
- oReadValid  out  1  oReadData valid for the current load.
- oMemReq  out  1  memory request, held until ack.
- oMemWe  out  1  1 = memory write.
- oMemAddr  out  DATA_WIDTH  word-aligned address ([1:0]=0).
- oMemWData  out  DATA_WIDTH  write data.
- oMemByteEn  out  4  write lanes.
- iMemAck  in  1  memory completes the transaction this cycle.
- iMemRData  in  DATA_WIDTH  read data, valid with iMemAck on reads.
- oHitCount  out  32  load hits, wraps.
- oMissCount  out  32  load misses, wraps.

## Operation
- Storage: per line valid bit, tag, data word. Lookup is combinational from iAddress: hit = valid[index] && tag match.
- States: IDLE, READ_WAIT, WRITE_WAIT, DONE.
- IDLE, iFlush=1: clear all valid bits; oStall=1 if iReq; stay IDLE. Flush has priority over a same-cycle request.
- IDLE, load hit: oReadData = line data, oReadValid=1, oStall=0, oHitCount+1; stay IDLE.
- IDLE, load miss: oStall=1, oMissCount+1, capture word address; go READ_WAIT.
- IDLE, store (hit or miss): oStall=1, capture address, data, byte enables; go WRITE_WAIT.
- READ_WAIT: oMemReq=1, oMemWe=0. On iMemAck: write valid=1, tag and iMemRData into line; capture iMemRData in the return register; go DONE.
- WRITE_WAIT: oMemReq=1, oMemWe=1, oMemWData/oMemByteEn from captured values. On iMemAck: if the line hits the captured tag, merge enabled bytes into the line; a miss does not allocate. Go DONE.
- DONE: oStall=0, so the held request retires at this edge. For a load, oReadData = return register and oReadValid=1. Go IDLE. iFlush in DONE is ignored; upstream must re-assert it.
- While in READ_WAIT or WRITE_WAIT, oStall=1. Changes on iReq, iAddress or data are ignored; the transaction uses captured copies and always completes.
- A store with iByteEn=0 is still issued to memory; line contents are unchanged.
- Only loads are counted. Flush does not clear the counters.

## Timing
- Reset: state IDLE, all valid bits 0, counters 0. oStall, oReadValid, oMemReq and oMemWe are 0. oReadData, oMemAddr, oMemWData and oMemByteEn are 0.
- Reset in any state aborts the transaction; oMemReq is 0 from the cycle after iRst is sampled.
- Load hit: 0-cycle latency, combinational.
- Load miss: stall cycles = (cycles to ack) + 1. With ack in the first READ_WAIT cycle, oStall is high for 2 cycles and data is returned in DONE (cycle 3).
- Store: same sequence, using WRITE_WAIT.
- oMemReq and its address/data are registered (Moore) and stable until the ack cycle inclusive. iMemAck is ignored when oMemReq=0.

## Test plan
- Reset, then load 0x0000_0040 -> miss: oMemReq in cycle 1 with oMemAddr=0x40. Ack in cycle 1 with 0xDEAD_BEEF -> DONE in cycle 2 with oReadData=0xDEADBEEF and oReadValid=1. oMissCount=1.
- Repeat load 0x43 -> 0-cycle hit: oReadData=0xDEADBEEF, oStall=0, oHitCount=1, no oMemReq.
- Store 0x0000_00AA00 at 0x41 with iByteEn=4'b0010 -> oMemWe=1, oMemByteEn=0010. After ack, load 0x40 hits and returns 0xDEADAAEF.
- Conflict: load 0x440 (same index, different tag) -> miss and refill; a following load of 0x40 misses again.
- Ack delayed 5 cycles while iAddress changes during the wait -> oMemAddr is unchanged and oStall is high for 6 cycles. Then iFlush in IDLE -> the next load of 0x40 misses.
- iRst asserted mid READ_WAIT -> oMemReq=0 the next cycle, counters 0, load 0x40 misses.
